// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-control bundle between the core datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if;
    logic        exc_valid_i;
    logic [31:0] exc_vector_i;
    logic        dc_miss_i;
    logic        dc_ready_i;
    logic        ic_miss_i;
    logic        ic_ready_i;
    logic        br_taken_i;
    logic [31:0] br_target_i;
    logic [4:0]  dec_rs1_i;
    logic [4:0]  dec_rs2_i;
    logic [4:0]  ex_rd_i;
    logic        ex_is_load_i;
    logic        stall_core_o;
    logic        stall_front_o;
    logic        bubble_de_o;
    logic        flush_fd_o;
    logic        flush_de_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        ic_abort_o;
    logic        dc_abort_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;

    modport master (
        output exc_valid_i, exc_vector_i, dc_miss_i, dc_ready_i, ic_miss_i, ic_ready_i,
               br_taken_i, br_target_i, dec_rs1_i, dec_rs2_i, ex_rd_i, ex_is_load_i,
        input  stall_core_o, stall_front_o, bubble_de_o, flush_fd_o, flush_de_o,
               redirect_o, redirect_pc_o, ic_abort_o, dc_abort_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  exc_valid_i, exc_vector_i, dc_miss_i, dc_ready_i, ic_miss_i, ic_ready_i,
               br_taken_i, br_target_i, dec_rs1_i, dec_rs2_i, ex_rd_i, ex_is_load_i,
        output stall_core_o, stall_front_o, bubble_de_o, flush_fd_o, flush_de_o,
               redirect_o, redirect_pc_o, ic_abort_o, dc_abort_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: arbitrates exceptions, cache misses, branches and
// load-use hazards into per-cycle pipeline strobes, and counts stall/flush cycles.
module pipe_hazard_ctrl #(
    parameter int unsigned EXC_PENALTY = 2
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    pipe_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {RUN, IC_WAIT, DC_WAIT, EXC} state_t;

    localparam logic [3:0] EXC_RELOAD = 4'(EXC_PENALTY - 1);

    state_t      state_q, state_d;
    logic [3:0]  excCnt_q, excCnt_d;
    logic [31:0] stallCnt_q, flushCnt_q;

    logic        stallCore, stallFront, bubbleDe, flushFd, flushDe;
    logic        redirect, icAbort, dcAbort;
    logic [31:0] redirectPc;
    logic        loadUse;

    assign loadUse = bus.ex_is_load_i && (bus.ex_rd_i != 5'd0) &&
                     ((bus.ex_rd_i == bus.dec_rs1_i) || (bus.ex_rd_i == bus.dec_rs2_i));

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q    <= RUN;
            excCnt_q   <= 4'd0;
            stallCnt_q <= 32'd0;
            flushCnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            excCnt_q   <= excCnt_d;
            stallCnt_q <= stallCnt_q + {31'd0, (stallCore | stallFront)};
            flushCnt_q <= flushCnt_q + {31'd0, flushFd};
        end
    end

    // Fixed priority in every state: exception > D-miss > branch > I-miss > load-use.
    always_comb begin
        state_d    = state_q;
        excCnt_d   = excCnt_q;
        stallCore  = 1'b0;
        stallFront = 1'b0;
        bubbleDe   = 1'b0;
        flushFd    = 1'b0;
        flushDe    = 1'b0;
        redirect   = 1'b0;
        redirectPc = 32'd0;
        icAbort    = 1'b0;
        dcAbort    = 1'b0;

        if (bus.exc_valid_i) begin
            flushFd    = 1'b1;
            flushDe    = 1'b1;
            redirect   = 1'b1;
            redirectPc = bus.exc_vector_i;
            icAbort    = (state_q == IC_WAIT) || bus.ic_miss_i;
            dcAbort    = (state_q == DC_WAIT);
            excCnt_d   = EXC_RELOAD;
            state_d    = EXC;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.dc_miss_i) begin
                        stallCore = 1'b1;
                        state_d   = DC_WAIT;
                    end else if (bus.br_taken_i) begin
                        redirect   = 1'b1;
                        redirectPc = bus.br_target_i;
                        flushFd    = 1'b1;
                        flushDe    = 1'b1;
                        icAbort    = bus.ic_miss_i;
                    end else if (bus.ic_miss_i) begin
                        stallFront = 1'b1;
                        bubbleDe   = 1'b1;
                        state_d    = IC_WAIT;
                    end else if (loadUse) begin
                        stallFront = 1'b1;
                        bubbleDe   = 1'b1;
                    end
                end
                IC_WAIT: begin
                    if (bus.dc_miss_i) begin
                        stallCore = 1'b1;
                        state_d   = DC_WAIT;
                    end else if (bus.br_taken_i) begin
                        redirect   = 1'b1;
                        redirectPc = bus.br_target_i;
                        flushFd    = 1'b1;
                        flushDe    = 1'b1;
                        icAbort    = 1'b1;
                        state_d    = RUN;
                    end else if (bus.ic_ready_i) begin
                        state_d = RUN;
                    end else begin
                        stallFront = 1'b1;
                        bubbleDe   = 1'b1;
                    end
                end
                DC_WAIT: begin
                    if (bus.dc_ready_i) begin
                        state_d = RUN;
                    end else begin
                        stallCore = 1'b1;
                    end
                end
                EXC: begin
                    flushFd = 1'b1;
                    if (excCnt_q == 4'd0) begin
                        state_d = RUN;
                    end else begin
                        excCnt_d = excCnt_q - 4'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Strobes are Mealy, so they are gated with reset to drop instantly, clock or not.
    assign bus.stall_core_o  = rsn_i & stallCore;
    assign bus.stall_front_o = rsn_i & stallFront;
    assign bus.bubble_de_o   = rsn_i & bubbleDe;
    assign bus.flush_fd_o    = rsn_i & flushFd;
    assign bus.flush_de_o    = rsn_i & flushDe;
    assign bus.redirect_o    = rsn_i & redirect;
    assign bus.redirect_pc_o = rsn_i ? redirectPc : 32'd0;
    assign bus.ic_abort_o    = rsn_i & icAbort;
    assign bus.dc_abort_o    = rsn_i & dcAbort;
    assign bus.stall_cnt_o   = stallCnt_q;
    assign bus.flush_cnt_o   = flushCnt_q;

endmodule
